// File: rtl/seg_message_display.sv
// Seven-segment message display: loads a short character message and shows
// it static, blinking or scrolling across N_DIGITS digits, one tick per
// TICK_DIV clock cycles. Segment outputs are registered and active-low.
module seg_message_display #(
    parameter int N_DIGITS = 6,
    parameter int MSG_LEN  = 8,
    parameter int TICK_DIV = 25000000
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    load_valid_i,
    output logic                    load_ready_o,
    input  logic [5*MSG_LEN-1:0]    load_data_i,
    input  logic [1:0]              mode_i,
    output logic [7*N_DIGITS-1:0]   LED_o,
    output logic                    scroll_wrap_o
);
    localparam int CW = $clog2(TICK_DIV);
    localparam int OW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

    typedef enum logic [1:0] {BLANK, LOAD, RUN} state_t;

    state_t                    state;
    logic [MSG_LEN-1:0][4:0]   buffer;
    logic [1:0]                mode;
    logic [CW-1:0]             cnt;
    logic [OW-1:0]             offset;
    logic                      phase;
    logic                      accept;
    logic                      tick;
    logic                      is_blink;
    logic                      is_scroll;
    logic [7*N_DIGITS-1:0]     image;

    // Active-low gfedcba glyph for a 5-bit character code
    function automatic logic [6:0] glyph(input logic [4:0] c);
        case (c)
            5'h00: glyph = 7'b1000000;
            5'h01: glyph = 7'b1111001;
            5'h02: glyph = 7'b0100100;
            5'h03: glyph = 7'b0110000;
            5'h04: glyph = 7'b0011001;
            5'h05: glyph = 7'b0010010;
            5'h06: glyph = 7'b0000010;
            5'h07: glyph = 7'b1111000;
            5'h08: glyph = 7'b0000000;
            5'h09: glyph = 7'b0010000;
            5'h0A: glyph = 7'b0001000;
            5'h0B: glyph = 7'b0000011;
            5'h0C: glyph = 7'b1000110;
            5'h0D: glyph = 7'b0100001;
            5'h0E: glyph = 7'b0000110;
            5'h0F: glyph = 7'b0001110;
            5'h11: glyph = 7'b0111111;
            5'h12: glyph = 7'b1000111;
            5'h13: glyph = 7'b1000001;
            5'h14: glyph = 7'b1111001;
            5'h15: glyph = 7'b0101111;
            5'h16: glyph = 7'b0101011;
            5'h17: glyph = 7'b0001100;
            5'h18: glyph = 7'b0001001;
            5'h19: glyph = 7'b0100011;
            default: glyph = 7'b1111111;
        endcase
    endfunction

    // Character at buffer position i; any position outside the buffer is blank
    function automatic logic [4:0] char_at(input logic [MSG_LEN-1:0][4:0] b, input int i);
        char_at = 5'h10;
        for (int m = 0; m < MSG_LEN; m++)
            if (m == i) char_at = b[m];
    endfunction

    assign is_blink      = (mode == 2'b01);
    assign is_scroll     = (mode == 2'b10);
    assign load_ready_o  = (state != LOAD) && !reset_i;
    assign accept        = load_valid_i && load_ready_o;
    assign tick          = (state == RUN) && (cnt == CW'(TICK_DIV - 1));
    // A tick that coincides with a new message is swallowed, so no wrap pulse then
    assign scroll_wrap_o = tick && is_scroll && (offset == OW'(MSG_LEN - 1)) && !accept && !reset_i;

    // Next display image from current registers; LOAD already shows the new message
    always_comb begin
        image = '1;
        for (int k = 0; k < N_DIGITS; k++)
            image[7*k +: 7] = glyph(char_at(buffer,
                is_scroll ? (int'(offset) + N_DIGITS - 1 - k) % MSG_LEN
                          : ((N_DIGITS - 1 - k < MSG_LEN) ? N_DIGITS - 1 - k : -1)));
        if (state == BLANK || (is_blink && !phase))
            image = '1;
    end

    // Control FSM, tick/offset/phase bookkeeping and registered segment output
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state  <= BLANK;
            buffer <= {MSG_LEN{5'h10}};
            mode   <= 2'b00;
            cnt    <= '0;
            offset <= '0;
            phase  <= 1'b1;
            LED_o  <= '1;
        end else begin
            LED_o <= image;
            if (accept) begin
                buffer <= load_data_i;
                mode   <= mode_i;
                cnt    <= '0;
                offset <= '0;
                phase  <= 1'b1;
                state  <= LOAD;
            end else if (state == LOAD) begin
                state <= RUN;
            end else if (state == RUN) begin
                cnt <= tick ? '0 : cnt + 1'b1;
                if (tick) begin
                    phase <= ~phase;
                    if (is_scroll)
                        offset <= (offset == OW'(MSG_LEN - 1)) ? '0 : offset + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_seg_message_display.sv
// Randomized self-checking bench for seg_message_display (6 digits, 8 chars,
// tick every 4 cycles). Reference model works from elapsed cycles since the
// accepting edge rather than from counters.
module tb_seg_message_display;
    localparam int ND = 6;
    localparam int ML = 8;
    localparam int TD = 4;

    logic            clk_i = 1'b0;
    logic            reset_i = 1'b1;
    logic            load_valid_i = 1'b0;
    logic            load_ready_o;
    logic [5*ML-1:0] load_data_i = '0;
    logic [1:0]      mode_i = 2'b00;
    logic [7*ND-1:0] LED_o;
    logic            scroll_wrap_o;

    seg_message_display #(.N_DIGITS(ND), .MSG_LEN(ML), .TICK_DIV(TD)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .load_valid_i(load_valid_i),
        .load_ready_o(load_ready_o), .load_data_i(load_data_i), .mode_i(mode_i),
        .LED_o(LED_o), .scroll_wrap_o(scroll_wrap_o));

    always #5 clk_i = ~clk_i;

    localparam logic [6:0] GLY [32] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
        7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110,
        7'b1111111, 7'b0111111, 7'b1000111, 7'b1000001, 7'b1111001, 7'b0101111,
        7'b0101011, 7'b0001100, 7'b0001001, 7'b0100011,
        7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111};

    int nvec = 0;
    int nerr = 0;
    int wraps = 0;

    // Model: loaded message, its mode and edges elapsed since acceptance
    bit         m_loaded = 0;
    int         m_e = 0;
    logic [4:0] m_buf [ML];
    logic [1:0] m_mode = 2'b00;

    localparam logic [39:0] SEQ = {5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0};

    function automatic logic [7*ND-1:0] model_image();
        logic [7*ND-1:0] img;
        int r, tcount, j, code;
        img = '1;
        if (!m_loaded) return img;
        r = (m_e == 0) ? 0 : m_e - 1;
        tcount = r / TD;
        if (m_mode == 2'b01 && (tcount % 2) == 1) return img;
        for (int k = 0; k < ND; k++) begin
            j = ND - 1 - k;
            if (m_mode == 2'b10) code = int'(m_buf[(tcount % ML + j) % ML]);
            else code = (j < ML) ? int'(m_buf[j]) : 16;
            img[7*k +: 7] = GLY[code];
        end
        return img;
    endfunction

    task automatic step(input bit rst, input bit vld, input logic [1:0] md,
                        input logic [39:0] data, input string nm);
        bit exp_ready, exp_wrap, acc;
        int r;
        logic [7*ND-1:0] exp_led;
        reset_i = rst; load_valid_i = vld; mode_i = md; load_data_i = data;
        #1;
        exp_ready = !rst && !(m_loaded && m_e == 0);
        acc = vld && exp_ready;
        r = m_e - 1;
        exp_wrap = !rst && !acc && m_loaded && m_e >= 1 && m_mode == 2'b10 &&
                   (r % TD == TD - 1) && ((r / TD) % ML == ML - 1);
        nvec++;
        if (load_ready_o !== exp_ready) begin
            nerr++;
            $display("FAIL %s ready got %b want %b", nm, load_ready_o, exp_ready);
        end
        nvec++;
        if (scroll_wrap_o !== exp_wrap) begin
            nerr++;
            $display("FAIL %s wrap got %b want %b", nm, scroll_wrap_o, exp_wrap);
        end
        if (scroll_wrap_o === 1'b1) wraps++;
        exp_led = rst ? '1 : model_image();
        if (rst) m_loaded = 0;
        else if (acc) begin
            m_loaded = 1; m_e = 0; m_mode = md;
            for (int i = 0; i < ML; i++) m_buf[i] = data[5*i +: 5];
        end else if (m_loaded) m_e++;
        @(posedge clk_i);
        #1;
        nvec++;
        if (LED_o !== exp_led) begin
            nerr++;
            $display("FAIL %s led got %h want %h", nm, LED_o, exp_led);
        end
    endtask

    task automatic run_idle(input int n, input string nm);
        for (int i = 0; i < n; i++) step(0, 0, 2'b00, 40'h0, nm);
    endtask

    task automatic test_reset();
        step(1, 0, 2'b00, 40'h0, "reset");
        step(1, 1, 2'b10, SEQ, "reset_over_load");
        nvec++;
        if (LED_o !== 42'h3FF_FFFF_FFFF) begin
            nerr++;
            $display("FAIL reset_led got %h want %h", LED_o, 42'h3FF_FFFF_FFFF);
        end
        run_idle(3, "reset_idle");
    endtask

    task automatic test_static();
        step(0, 1, 2'b00, SEQ, "static_load");
        run_idle(41, "static");
        nvec++;
        if (LED_o !== {7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010}) begin
            nerr++;
            $display("FAIL static_image got %h want 0..5 glyphs", LED_o);
        end
    endtask

    task automatic test_blink();
        step(0, 1, 2'b01, SEQ, "blink_load");
        run_idle(24, "blink");
    endtask

    task automatic test_scroll();
        wraps = 0;
        step(0, 1, 2'b10, SEQ, "scroll_load");
        run_idle(70, "scroll");
        nvec++;
        if (wraps !== 2) begin
            nerr++;
            $display("FAIL scroll_wrap_count got %0d want 2", wraps);
        end
    endtask

    task automatic test_reset_mid_scroll();
        step(0, 1, 2'b10, SEQ, "mid_load");
        run_idle(13, "mid_scroll");
        step(1, 0, 2'b10, SEQ, "mid_reset");
        run_idle(2, "mid_blank");
        step(0, 1, 2'b10, SEQ, "mid_reload");
        run_idle(10, "mid_rescroll");
    endtask

    task automatic test_accept_on_wrap();
        logic [39:0] d;
        wraps = 0;
        step(0, 1, 2'b10, SEQ, "aow_load");
        for (int i = 0; i < 200 && m_e != 32; i++) run_idle(1, "aow_wait");
        nvec++;
        if (m_e != 32) begin
            nerr++;
            $display("FAIL aow_timeout got %0d want 32", m_e);
        end
        d = {$urandom, $urandom};
        step(0, 1, 2'b10, d, "aow_accept");
        run_idle(12, "aow_after");
        nvec++;
        if (wraps !== 0) begin
            nerr++;
            $display("FAIL aow_wrap_count got %0d want 0", wraps);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++)
            step(0, 1, 2'($urandom_range(0, 3)), {$urandom, $urandom}, "b2b");
        run_idle(6, "b2b_tail");
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0,
                 2'($urandom_range(0, 3)), {$urandom, $urandom}, "random");
    endtask

    initial begin
        for (int i = 0; i < ML; i++) m_buf[i] = 5'h10;
        test_reset();
        test_static();
        test_blink();
        test_scroll();
        test_reset_mid_scroll();
        test_accept_on_wrap();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
